// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the future transmit
// path): the receiver state encoding and the oversampling constants.
// No ports; imported by uart_rx_core and uart_sync_fifo.
// ---------------------------------------------------------------------------
package uart_pkg;

   // Receiver states. BREAK parks the receiver while the line is held low
   // after a framing error so a long low level cannot retrigger a frame.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_t;

   // Ticks per bit, the tick count within the start bit at which the line
   // is sampled (mid-bit), and the number of data bits per frame.
   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_MID_SAMPLE = 7;
   localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Small synchronous FIFO with a combinational head view. A pop on an empty
// FIFO is ignored; a push on a full FIFO is dropped unless a pop happens in
// the same cycle, in which case both take effect.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   synchronous reset, active-high (empties FIFO, clears memory)
//   push_i   in   write data_i this cycle
//   pop_i    in   advance head this cycle
//   data_i   in   WIDTH-bit write data
//   head_o   out  WIDTH-bit oldest entry (meaningful only when not empty)
//   full_o   out  DEPTH entries stored
//   empty_o  out  no entries stored
// ---------------------------------------------------------------------------
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;

   logic w_doPush;
   logic w_doPop;

   // The count is one bit wider than the pointers so that full and empty
   // are distinguishable when the pointers are equal. A push into a full
   // FIFO is only accepted when a pop frees a slot in the same cycle.
   always_comb begin
      empty_o  = (r_count == '0);
      full_o   = (r_count == CNT_FULL);
      w_doPop  = pop_i & ~empty_o;
      w_doPush = push_i & (~full_o | w_doPop);
      head_o   = r_mem[r_rdPtr];
   end

   // Storage and pointer update. Pointers wrap naturally because DEPTH is
   // a power of two. Memory is cleared on reset so the head reads zero
   // while the FIFO is empty after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= data_i;
            r_wrPtr        <= r_wrPtr + PTR_ONE;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver with 16x oversampling. The serial input is
// synchronised, a programmable tick generator produces the oversample
// strobe, and a small FSM validates the start bit, shifts in eight data
// bits LSB-first and checks the stop bit. Good bytes are queued in a
// receive FIFO; framing errors and overruns raise sticky flags.
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous reset, active-high
//   divisor_i    in   clk cycles per oversample tick (0 behaves as 1)
//   rx_i         in   asynchronous serial line, idle high
//   data_o       out  FIFO head byte, meaningful while valid_o=1
//   valid_o      out  FIFO not empty
//   rd_i         in   pop the FIFO head (ignored while valid_o=0)
//   frame_err_o  out  sticky: stop bit sampled low
//   overrun_o    out  sticky: byte completed while FIFO full
//   clr_err_i    in   clears both sticky flags (a same-cycle set wins)
//   busy_o       out  receiver FSM not idle
// ---------------------------------------------------------------------------
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] divisor_i,
   input  logic        rx_i,
   output logic [7:0]  data_o,
   output logic        valid_o,
   input  logic        rd_i,
   output logic        frame_err_o,
   output logic        overrun_o,
   input  logic        clr_err_i,
   output logic        busy_o
);

   localparam logic [3:0] SCNT_MID  = 4'(UART_MID_SAMPLE);
   localparam logic [3:0] SCNT_LAST = 4'(UART_OVERSAMPLE - 1);
   localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_BITS - 1);

   logic                      r_sync1;
   logic                      r_sync2;
   logic                      w_rxS;

   logic [15:0]               r_tickCnt;
   logic [15:0]               w_reload;
   logic                      w_tick;

   uart_rx_state_t            r_state;
   uart_rx_state_t            w_stateNext;
   logic [3:0]                r_scnt;
   logic [3:0]                w_scntNext;
   logic [2:0]                r_bitIdx;
   logic [2:0]                w_bitIdxNext;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_DATA_BITS-1:0] w_shiftNext;
   logic                      r_busy;

   logic                      w_push;
   logic                      w_frameErrSet;
   logic                      w_overrunSet;
   logic                      w_popEff;
   logic                      r_frameErr;
   logic                      r_overrun;

   logic [UART_DATA_BITS-1:0] w_fifoHead;
   logic                      w_fifoFull;
   logic                      w_fifoEmpty;

   // Two-flop synchroniser for the asynchronous serial line. Both flops
   // reset to the idle (high) level so reset never looks like a start bit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx_i;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxS = r_sync2;

   // Oversample tick generator. A down-counter strobes the tick when it
   // reaches zero and reloads from the divisor at that point, so a new
   // divisor value is only picked up at the next reload. A divisor of zero
   // reloads zero, giving a tick every clock just like a divisor of one.
   always_comb begin
      w_reload = (divisor_i == 16'd0) ? 16'd0 : (divisor_i - 16'd1);
      w_tick   = (r_tickCnt == 16'd0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tickCnt <= 16'd0;
      end else if (w_tick) begin
         r_tickCnt <= w_reload;
      end else begin
         r_tickCnt <= r_tickCnt - 16'd1;
      end
   end

   // Receiver next-state logic. The sample counter is cleared on entry to
   // every state. The start bit is re-checked after eight ticks (mid-bit)
   // so short glitches fall back to IDLE without touching any flag. From
   // then on every sixteenth tick lands in the middle of a bit, which is
   // where data and stop bits are sampled. A low stop bit discards the
   // byte and parks in BREAK until the line returns high.
   always_comb begin
      w_stateNext   = r_state;
      w_scntNext    = r_scnt;
      w_bitIdxNext  = r_bitIdx;
      w_shiftNext   = r_shift;
      w_push        = 1'b0;
      w_frameErrSet = 1'b0;

      case (r_state)
         IDLE: begin
            if (!w_rxS) begin
               w_stateNext = START;
               w_scntNext  = 4'd0;
            end
         end

         START: begin
            if (w_tick) begin
               if (r_scnt == SCNT_MID) begin
                  w_scntNext = 4'd0;
                  if (!w_rxS) begin
                     w_stateNext  = DATA;
                     w_bitIdxNext = 3'd0;
                  end else begin
                     w_stateNext = IDLE;
                  end
               end else begin
                  w_scntNext = r_scnt + 4'd1;
               end
            end
         end

         DATA: begin
            if (w_tick) begin
               w_scntNext = r_scnt + 4'd1;
               if (r_scnt == SCNT_LAST) begin
                  w_shiftNext  = {w_rxS, r_shift[UART_DATA_BITS-1:1]};
                  w_bitIdxNext = r_bitIdx + 3'd1;
                  if (r_bitIdx == BIT_LAST) begin
                     w_stateNext = STOP;
                     w_scntNext  = 4'd0;
                  end
               end
            end
         end

         STOP: begin
            if (w_tick) begin
               w_scntNext = r_scnt + 4'd1;
               if (r_scnt == SCNT_LAST) begin
                  w_scntNext = 4'd0;
                  if (w_rxS) begin
                     w_push      = 1'b1;
                     w_stateNext = IDLE;
                  end else begin
                     w_frameErrSet = 1'b1;
                     w_stateNext   = BREAK;
                  end
               end
            end
         end

         BREAK: begin
            if (w_rxS) begin
               w_stateNext = IDLE;
               w_scntNext  = 4'd0;
            end
         end

         default: begin
            w_stateNext = IDLE;
            w_scntNext  = 4'd0;
         end
      endcase
   end

   // Receiver state register. busy is registered from the next state so
   // it changes on exactly the same clock edge as the state itself.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_scnt   <= 4'd0;
         r_bitIdx <= 3'd0;
         r_shift  <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_scnt   <= w_scntNext;
         r_bitIdx <= w_bitIdxNext;
         r_shift  <= w_shiftNext;
         r_busy   <= (w_stateNext != IDLE);
      end
   end

   // Receive FIFO. The completed byte is pushed on the stop-sample tick so
   // it is visible at the head on the following clock.
   uart_sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .pop_i   (rd_i),
      .data_i  (r_shift),
      .head_o  (w_fifoHead),
      .full_o  (w_fifoFull),
      .empty_o (w_fifoEmpty)
   );

   // An overrun only happens when the FIFO is full and no read frees a
   // slot in the same cycle; a simultaneous read lets the byte in.
   always_comb begin
      w_popEff     = rd_i & ~w_fifoEmpty;
      w_overrunSet = w_push & w_fifoFull & ~w_popEff;
   end

   // Sticky error flags. A set in the same cycle as a clear wins so an
   // error arriving while software clears the flags is never lost.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_frameErr <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_frameErrSet) begin
            r_frameErr <= 1'b1;
         end else if (clr_err_i) begin
            r_frameErr <= 1'b0;
         end
         if (w_overrunSet) begin
            r_overrun <= 1'b1;
         end else if (clr_err_i) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign data_o      = w_fifoHead;
   assign valid_o     = ~w_fifoEmpty;
   assign frame_err_o = r_frameErr;
   assign overrun_o   = r_overrun;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
// Self-checking bench for uart_rx_core. Serial frames are driven on the rx
// line with divisor 4 (64 clocks per bit). Every byte that should land in
// the receive FIFO is queued when its frame is driven and compared when it
// is read back.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_core;

   localparam int BIT_CLKS = 64;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] divisor;
   logic        rxLine;
   logic [7:0]  dataOut;
   logic        validOut;
   logic        rdIn;
   logic        frameErr;
   logic        overrun;
   logic        clrErr;
   logic        busy;

   int          checkCount = 0;
   int          errorCount = 0;
   logic [7:0]  expQ[$];
   int unsigned cyc = 0;

   uart_rx_core #(
      .FIFO_DEPTH (4)
   ) dut (
      .clk_i       (clock),
      .rst_i       (reset),
      .divisor_i   (divisor),
      .rx_i        (rxLine),
      .data_o      (dataOut),
      .valid_o     (validOut),
      .rd_i        (rdIn),
      .frame_err_o (frameErr),
      .overrun_o   (overrun),
      .clr_err_i   (clrErr),
      .busy_o      (busy)
   );

   // Free-running clock and an edge counter used to line stimulus up with
   // the receiver's tick phase.
   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc <= cyc + 1;
   end

   // Hard stop in case the bench ever wedges.
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Start bit plus eight data bits, LSB first; the stop bit is left to
   // the caller.
   task automatic sendData(input logic [7:0] d);
      rxLine = 1'b0;
      waitClocks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rxLine = d[i];
         waitClocks(BIT_CLKS);
      end
   endtask

   // Whole frame. stopLowBits>0 holds the line low for that many bit times
   // in place of the stop bit, then returns it high for one bit time.
   task automatic applyStimulus(input logic [7:0] d, input int stopLowBits);
      sendData(d);
      if (stopLowBits > 0) begin
         rxLine = 1'b0;
         waitClocks(BIT_CLKS * stopLowBits);
      end
      rxLine = 1'b1;
      waitClocks(BIT_CLKS);
   endtask

   // Drain the FIFO, comparing each head byte against the scoreboard.
   task automatic readAll(input string tag);
      for (int n = 0; n < 8 && validOut; n++) begin
         if (expQ.size() == 0) begin
            checkOutput({tag, "Unexpected"}, {31'd0, validOut}, 32'd0);
         end else begin
            checkOutput({tag, "Data"}, {24'd0, dataOut}, {24'd0, expQ.pop_front()});
         end
         rdIn = 1'b1;
         @(negedge clock);
         rdIn = 1'b0;
      end
      checkOutput({tag, "Empty"}, {31'd0, validOut}, 32'd0);
      checkOutput({tag, "Left"}, expQ.size(), 32'd0);
   endtask

   initial begin
      int unsigned t0;
      int unsigned dEdge;
      int unsigned t1;
      int unsigned pEdge;
      int          k;
      logic        found;
      logic [7:0]  v;

      reset   = 1'b1;
      divisor = 16'd4;
      rxLine  = 1'b1;
      rdIn    = 1'b0;
      clrErr  = 1'b0;
      waitClocks(5);

      // Reset state
      checkOutput("rstData", {24'd0, dataOut}, 32'h00);
      checkOutput("rstValid", {31'd0, validOut}, 32'd0);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstFerr", {31'd0, frameErr}, 32'd0);
      checkOutput("rstOvr", {31'd0, overrun}, 32'd0);
      reset = 1'b0;
      waitClocks(20);

      // 1: single byte, valid rises just after the mid-stop sample
      sendData(8'hA5);
      rxLine = 1'b1;
      waitClocks(20);
      checkOutput("t1ValidEarly", {31'd0, validOut}, 32'd0);
      waitClocks(44);
      checkOutput("t1ValidLate", {31'd0, validOut}, 32'd1);
      checkOutput("t1BusyIdle", {31'd0, busy}, 32'd0);
      expQ.push_back(8'hA5);
      readAll("t1");

      // 2: short low glitch is rejected
      rxLine = 1'b0;
      waitClocks(20);
      checkOutput("t2BusyDuring", {31'd0, busy}, 32'd1);
      rxLine = 1'b1;
      waitClocks(100);
      checkOutput("t2Valid", {31'd0, validOut}, 32'd0);
      checkOutput("t2Busy", {31'd0, busy}, 32'd0);
      checkOutput("t2Ferr", {31'd0, frameErr}, 32'd0);
      checkOutput("t2Ovr", {31'd0, overrun}, 32'd0);

      // 3: stop bit held low for three bit times
      sendData(8'h3C);
      rxLine = 1'b0;
      waitClocks(3 * BIT_CLKS);
      checkOutput("t3BusyBreak", {31'd0, busy}, 32'd1);
      checkOutput("t3Ferr", {31'd0, frameErr}, 32'd1);
      checkOutput("t3Valid", {31'd0, validOut}, 32'd0);
      rxLine = 1'b1;
      waitClocks(BIT_CLKS);
      checkOutput("t3BusyIdle", {31'd0, busy}, 32'd0);
      applyStimulus(8'h11, 0);
      expQ.push_back(8'h11);
      waitClocks(10);
      readAll("t3");
      clrErr = 1'b1;
      waitClocks(1);
      clrErr = 1'b0;
      checkOutput("t3FerrClr", {31'd0, frameErr}, 32'd0);

      // 4: five back-to-back bytes into a four-entry FIFO
      for (int b = 1; b <= 5; b++) begin
         v = 8'(b);
         applyStimulus(v, 0);
         if (b <= 4) expQ.push_back(v);
      end
      waitClocks(10);
      checkOutput("t4Ovr", {31'd0, overrun}, 32'd1);
      checkOutput("t4Ferr", {31'd0, frameErr}, 32'd0);
      readAll("t4");
      clrErr = 1'b1;
      waitClocks(1);
      clrErr = 1'b0;
      checkOutput("t4OvrClr", {31'd0, overrun}, 32'd0);

      // 5: reset in the middle of a frame empties the FIFO and idles the FSM
      applyStimulus(8'h99, 0);
      waitClocks(10);
      checkOutput("t5PreValid", {31'd0, validOut}, 32'd1);
      rxLine = 1'b0;
      waitClocks(BIT_CLKS);
      v = 8'h7E;
      for (int i = 0; i < 3; i++) begin
         rxLine = v[i];
         waitClocks(BIT_CLKS);
      end
      rxLine = v[3];
      waitClocks(BIT_CLKS / 2);
      checkOutput("t5BusyPre", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      waitClocks(1);
      reset = 1'b0;
      checkOutput("t5Valid", {31'd0, validOut}, 32'd0);
      checkOutput("t5Busy", {31'd0, busy}, 32'd0);
      checkOutput("t5Data", {24'd0, dataOut}, 32'h00);
      rxLine = 1'b1;
      waitClocks(200);
      checkOutput("t5ValidIdle", {31'd0, validOut}, 32'd0);
      applyStimulus(8'h42, 0);
      expQ.push_back(8'h42);
      waitClocks(10);
      readAll("t5");

      // 6a: fill the FIFO, then pop on the very edge the fifth byte lands
      for (int b = 1; b <= 4; b++) begin
         v = 8'h60 + 8'(b);
         applyStimulus(v, 0);
         expQ.push_back(v);
      end
      waitClocks(10);
      // A glitch returns to IDLE on a tick edge, revealing the tick phase.
      rxLine = 1'b0;
      waitClocks(20);
      checkOutput("t6GlitchBusy", {31'd0, busy}, 32'd1);
      rxLine = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clock);
         if (!busy) begin
            found = 1'b1;
            break;
         end
      end
      t0 = cyc;
      checkOutput("t6PhaseFound", {31'd0, found}, 32'd1);
      waitClocks(20);
      rxLine = 1'b0;
      found = 1'b0;
      k = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clock);
         k++;
         if (busy) begin
            found = 1'b1;
            break;
         end
      end
      dEdge = cyc;
      checkOutput("t6StartSeen", {31'd0, found}, 32'd1);
      // First tick after entering START, then 151 more ticks to the
      // stop-bit sample (8 in START, 16 per data bit, 16 in STOP).
      t1    = t0 + 4 * ((dEdge - t0) / 4 + 1);
      pEdge = t1 + 604;
      v = 8'h65;
      fork
         begin
            waitClocks(BIT_CLKS - k);
            for (int i = 0; i < 8; i++) begin
               rxLine = v[i];
               waitClocks(BIT_CLKS);
            end
            rxLine = 1'b1;
            waitClocks(BIT_CLKS);
         end
         begin
            while (cyc < pEdge - 1) @(negedge clock);
            checkOutput("t6FullValid", {31'd0, validOut}, 32'd1);
            checkOutput("t6PopData", {24'd0, dataOut}, {24'd0, expQ.pop_front()});
            rdIn = 1'b1;
            @(negedge clock);
            rdIn = 1'b0;
         end
      join
      expQ.push_back(8'h65);
      waitClocks(10);
      checkOutput("t6NoOvr", {31'd0, overrun}, 32'd0);
      readAll("t6");

      // 6b: clear held through the framing error; the set must win
      checkOutput("t6FerrPre", {31'd0, frameErr}, 32'd0);
      clrErr = 1'b1;
      found  = 1'b0;
      fork
         applyStimulus(8'h5A, 2);
         begin
            for (int n = 0; n < 2000; n++) begin
               @(negedge clock);
               if (frameErr) begin
                  found  = 1'b1;
                  clrErr = 1'b0;
                  break;
               end
            end
         end
      join
      clrErr = 1'b0;
      waitClocks(5);
      checkOutput("t6FerrSeen", {31'd0, found}, 32'd1);
      checkOutput("t6FerrHeld", {31'd0, frameErr}, 32'd1);
      checkOutput("t6FerrValid", {31'd0, validOut}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
